// File: rtl/p2s_pkg.sv
// p2s_pkg: step codes, sizes and FSM state type shared by the
// parallel-to-serial sequencer and the buffer that decodes its ctrl.
package p2s_pkg;

   // ctrl step codes seen by the parallel-to-serial buffer
   localparam logic [3:0] CTRL_IDLE = 4'd0;
   localparam logic [3:0] CTRL_LOAD = 4'd8;
   localparam logic [3:0] CTRL_BASE = 4'd9;

   // elements per vector and the last element index
   localparam int unsigned N_ELEM   = 5;
   localparam logic [2:0]  LAST_IDX = 3'(N_ELEM - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT
   } state_t;

   // ctrl code that selects element i of the loaded vector
   function automatic logic [3:0] elem_ctrl(input logic [2:0] i);
      return CTRL_BASE + {1'b0, i};
   endfunction

endpackage

// File: rtl/p2s_seq.sv
// p2s_seq: sequences LOAD/SHIFT steps of a parallel-to-serial buffer
// for a job of count 5-element vectors on a selected layer.
//   in : clk, rst (sync, active-high), start, layer[3:0], count[3:0],
//        stall, abort
//   out: ctrl[3:0], sel[3:0], valid, idx[2:0], vec[3:0], busy, done, err
module p2s_seq
   import p2s_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] layer,
   input  logic [3:0] count,
   input  logic       stall,
   input  logic       abort,
   output logic [3:0] ctrl,
   output logic [3:0] sel,
   output logic       valid,
   output logic [2:0] idx,
   output logic [3:0] vec,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_t     state;
   logic [3:0] cnt_q;

   logic       last_elem;
   logic       more_vecs;

   assign last_elem = (idx == LAST_IDX);
   // vec never exceeds 14, so vec+1 cannot overflow the compare
   assign more_vecs = ((vec + 4'd1) < cnt_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt_q <= 4'd0;
         ctrl  <= CTRL_IDLE;
         sel   <= 4'd0;
         valid <= 1'b0;
         idx   <= 3'd0;
         vec   <= 4'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         if (abort) begin
            // abort wins over stall and completion; no done pulse
            state <= ST_IDLE;
            ctrl  <= CTRL_IDLE;
            sel   <= 4'd0;
            valid <= 1'b0;
            idx   <= 3'd0;
            vec   <= 4'd0;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     if (layer != 4'd0 && count != 4'd0) begin
                        state <= ST_LOAD;
                        cnt_q <= count;
                        ctrl  <= CTRL_LOAD;
                        sel   <= layer;
                        valid <= 1'b0;
                        idx   <= 3'd0;
                        vec   <= 4'd0;
                        busy  <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end

               ST_LOAD: begin
                  if (stall) begin
                     valid <= 1'b0;
                  end else begin
                     state <= ST_SHIFT;
                     ctrl  <= elem_ctrl(3'd0);
                     idx   <= 3'd0;
                     valid <= 1'b1;
                  end
               end

               ST_SHIFT: begin
                  if (stall) begin
                     // hold position, only withdraw the valid
                     valid <= 1'b0;
                  end else if (!last_elem) begin
                     idx   <= idx + 3'd1;
                     ctrl  <= elem_ctrl(idx + 3'd1);
                     valid <= 1'b1;
                  end else if (more_vecs) begin
                     state <= ST_LOAD;
                     ctrl  <= CTRL_LOAD;
                     idx   <= 3'd0;
                     vec   <= vec + 4'd1;
                     valid <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                     ctrl  <= CTRL_IDLE;
                     sel   <= 4'd0;
                     idx   <= 3'd0;
                     vec   <= 4'd0;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end

               default: begin
                  state <= ST_IDLE;
                  ctrl  <= CTRL_IDLE;
                  sel   <= 4'd0;
                  valid <= 1'b0;
                  idx   <= 3'd0;
                  vec   <= 4'd0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_p2s_seq.sv
// tb_p2s_seq: directed self-checking bench for p2s_seq.
// Inputs change 1 time unit after a rising edge; outputs read there too.
module tb_p2s_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] layer;
   logic [3:0] count;
   logic       stall;
   logic       abort;
   logic [3:0] ctrl;
   logic [3:0] sel;
   logic       valid;
   logic [2:0] idx;
   logic [3:0] vec;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   p2s_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .layer (layer),
      .count (count),
      .stall (stall),
      .abort (abort),
      .ctrl  (ctrl),
      .sel   (sel),
      .valid (valid),
      .idx   (idx),
      .vec   (vec),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({ctrl, sel, valid, idx, vec, busy, done, err} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got ctrl=%0d sel=%0d valid=%0b idx=%0d vec=%0d busy=%0b done=%0b err=%0b exp all 0",
                  ctrl, sel, valid, idx, vec, busy, done, err);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || ctrl !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle_hold: got busy=%0b ctrl=%0d exp 0 0", busy, ctrl);
      end
   endtask

   task automatic test_single();
      logic [3:0] e;
      layer = 4'd3;
      count = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (ctrl !== 4'd8 || sel !== 4'd3 || busy !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL single_load: got ctrl=%0d sel=%0d busy=%0b valid=%0b exp 8 3 1 0",
                  ctrl, sel, busy, valid);
      end
      for (int i = 0; i < 5; i++) begin
         // a start while busy must be ignored
         start = (i == 2);
         layer = (i == 2) ? 4'd7 : 4'd3;
         tick();
         e = 4'(9 + i);
         checks++;
         if (ctrl !== e || valid !== 1'b1 || idx !== 3'(i) || vec !== 4'd0 || sel !== 4'd3) begin
            errors++;
            $display("FAIL single_shift%0d: got ctrl=%0d valid=%0b idx=%0d vec=%0d sel=%0d exp %0d 1 %0d 0 3",
                     i, ctrl, valid, idx, vec, sel, e, i);
         end
      end
      start = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ctrl !== 4'd0 || sel !== 4'd0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL single_done: got done=%0b busy=%0b ctrl=%0d sel=%0d valid=%0b exp 1 0 0 0 0",
                  done, busy, ctrl, sel, valid);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL single_done_pulse: got done=%0b exp 0", done);
      end
   endtask

   task automatic test_multi();
      logic [3:0] e;
      layer = 4'd1;
      count = 4'd3;
      start = 1'b1;
      for (int v = 0; v < 3; v++) begin
         tick();
         start = 1'b0;
         checks++;
         if (ctrl !== 4'd8 || vec !== 4'(v) || sel !== 4'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL multi_load%0d: got ctrl=%0d vec=%0d sel=%0d done=%0b exp 8 %0d 1 0",
                     v, ctrl, vec, sel, done, v);
         end
         for (int i = 0; i < 5; i++) begin
            tick();
            e = 4'(9 + i);
            checks++;
            if (ctrl !== e || vec !== 4'(v) || valid !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL multi_v%0d_e%0d: got ctrl=%0d vec=%0d valid=%0b done=%0b exp %0d %0d 1 0",
                        v, i, ctrl, vec, valid, done, e, v);
            end
         end
      end
      // 18 active cycles after the start edge, then the done cycle
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ctrl !== 4'd0) begin
         errors++;
         $display("FAIL multi_done: got done=%0b busy=%0b ctrl=%0d exp 1 0 0", done, busy, ctrl);
      end
   endtask

   task automatic test_stall();
      // stall in IDLE is ignored
      stall = 1'b1;
      layer = 4'd2;
      count = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      stall = 1'b0;
      checks++;
      if (ctrl !== 4'd8 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_idle: got ctrl=%0d busy=%0b exp 8 1", ctrl, busy);
      end
      tick();
      tick();
      checks++;
      if (ctrl !== 4'd10 || valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_pre: got ctrl=%0d valid=%0b exp 10 1", ctrl, valid);
      end
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (ctrl !== 4'd10 || valid !== 1'b0 || idx !== 3'd1 || sel !== 4'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold%0d: got ctrl=%0d valid=%0b idx=%0d sel=%0d busy=%0b exp 10 0 1 2 1",
                     k, ctrl, valid, idx, sel, busy);
         end
      end
      stall = 1'b0;
      tick();
      checks++;
      if (ctrl !== 4'd11 || valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume: got ctrl=%0d valid=%0b exp 11 1", ctrl, valid);
      end
      tick();
      tick();
      checks++;
      if (ctrl !== 4'd13 || done !== 1'b0) begin
         errors++;
         $display("FAIL stall_last: got ctrl=%0d done=%0b exp 13 0", ctrl, done);
      end
      // done lands at T+9 instead of T+7
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_done: got done=%0b busy=%0b exp 1 0", done, busy);
      end
   endtask

   task automatic test_abort();
      layer = 4'd5;
      count = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (ctrl !== 4'd12 || vec !== 4'd1) begin
         errors++;
         $display("FAIL abort_pre: got ctrl=%0d vec=%0d exp 12 1", ctrl, vec);
      end
      abort = 1'b1;
      stall = 1'b1;
      tick();
      abort = 1'b0;
      stall = 1'b0;
      checks++;
      if (ctrl !== 4'd0 || sel !== 4'd0 || busy !== 1'b0 || vec !== 4'd0 || valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got ctrl=%0d sel=%0d busy=%0b vec=%0d valid=%0b done=%0b exp 0 0 0 0 0 0",
                  ctrl, sel, busy, vec, valid, done);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone%0d: got done=%0b busy=%0b exp 0 0", k, done, busy);
         end
      end
   endtask

   task automatic test_illegal();
      layer = 4'd0;
      count = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ctrl !== 4'd0) begin
         errors++;
         $display("FAIL illegal_layer: got err=%0b busy=%0b ctrl=%0d exp 1 0 0", err, busy, ctrl);
      end
      tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0 || ctrl !== 4'd0) begin
         errors++;
         $display("FAIL illegal_layer_after: got err=%0b busy=%0b ctrl=%0d exp 0 0 0", err, busy, ctrl);
      end
      layer = 4'd4;
      count = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ctrl !== 4'd0) begin
         errors++;
         $display("FAIL illegal_count: got err=%0b busy=%0b ctrl=%0d exp 1 0 0", err, busy, ctrl);
      end
      tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_count_after: got err=%0b busy=%0b exp 0 0", err, busy);
      end
   endtask

   task automatic test_back_to_back();
      layer = 4'd3;
      count = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done: got done=%0b busy=%0b exp 1 0", done, busy);
      end
      layer = 4'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (ctrl !== 4'd8 || sel !== 4'd6 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_load: got ctrl=%0d sel=%0d busy=%0b exp 8 6 1", ctrl, sel, busy);
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({ctrl, sel, valid, idx, vec, busy, done, err} !== 19'd0) begin
         errors++;
         $display("FAIL midjob_reset: got ctrl=%0d sel=%0d valid=%0b idx=%0d vec=%0d busy=%0b done=%0b err=%0b exp all 0",
                  ctrl, sel, valid, idx, vec, busy, done, err);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (done !== 1'b0 || ctrl !== 4'd0) begin
            errors++;
            $display("FAIL reset_nodone%0d: got done=%0b ctrl=%0d exp 0 0", k, done, ctrl);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      layer = 4'd0;
      count = 4'd0;
      stall = 1'b0;
      abort = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_stall();
      test_abort();
      test_illegal();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/p2s_seq.md
P2S_SEQ -- requirements
Module: p2s_seq

Interface
REQ-001 The block SHALL use a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin a serialization job; sampled only in IDLE.
REQ-005 layer  input  4  layer select for the job; must be nonzero.
REQ-006 count  input  4  number of 5-element vectors in the job, 1..15.
REQ-007 stall  input  1  downstream back-pressure; freezes the sequence while high.
REQ-008 abort  input  1  terminates any job in progress.
REQ-009 ctrl  output  4  step code to the parallel-to-serial buffer: 0 idle, 8 load, 9..13 element 0..4.
REQ-010 sel  output  4  latched layer select driven to the buffer; 0 when idle.
REQ-011 valid  output  1  current serial element is valid downstream.
REQ-012 idx  output  3  element index 0..4 of the current serial element.
REQ-013 vec  output  4  index of the current vector within the job, 0..count-1.
REQ-014 busy  output  1  a job is in progress.
REQ-015 done  output  1  one-cycle pulse on normal job completion.
REQ-016 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and SHIFT; all outputs SHALL be registered.
REQ-018 IDLE SHALL drive ctrl=0, sel=0, valid=0 and busy=0.
REQ-019 Job acceptance: in IDLE, start=1 with layer!=0 and count!=0 SHALL latch layer and count and enter LOAD on the next cycle.
REQ-020 Start rejection: in IDLE, start=1 with layer=0 or count=0 SHALL pulse err for one cycle and remain in IDLE.
REQ-021 start SHALL be ignored whenever busy=1.
REQ-022 LOAD SHALL last one unstalled cycle and drive ctrl=8, sel=latched layer, busy=1, valid=0.
REQ-023 SHIFT SHALL step through 5 unstalled cycles, driving ctrl=9+idx with idx=0..4, valid=1 and busy=1.
REQ-024 Latency: for a start sampled at cycle T with no stall, ctrl=8 at T+1 and ctrl=9..13 at T+2..T+6.
REQ-025 After idx=4, if vec<count-1 the FSM SHALL increment vec and return to LOAD; otherwise it SHALL go to IDLE and pulse done.
REQ-026 done SHALL coincide with busy=0 and ctrl=0; a start sampled in that same cycle SHALL be accepted.
REQ-027 Stall (in LOAD or SHIFT) SHALL hold state, ctrl, idx, vec and sel unchanged and force valid=0.
REQ-028 stall SHALL have no effect in IDLE.
REQ-029 abort SHALL return the FSM to IDLE on the next cycle from any state, with ctrl=0, sel=0 and vec=0, and SHALL NOT pulse done.
REQ-030 abort SHALL take priority over stall and over vector completion.
REQ-031 The idx counter SHALL wrap 4->0 only on a transition to LOAD or IDLE, and SHALL never exceed 4.
REQ-032 ctrl SHALL never take values other than 0, 8 or 9..13.

Reset
REQ-033 rst SHALL have priority over all inputs.
REQ-034 In the cycle after rst is sampled high, outputs SHALL be: ctrl=0, sel=0, valid=0, idx=0, vec=0, busy=0, done=0, err=0; the FSM SHALL be in IDLE.
REQ-035 Reset asserted mid-job SHALL discard the job without a done pulse.

Structure
REQ-036 A shared package p2s_pkg SHALL hold the constants CTRL_IDLE=0, CTRL_LOAD=8, CTRL_BASE=9 and N_ELEM=5, plus the FSM state type; the existing buffer's ctrl decode SHALL use the same constants.
REQ-037 The block SHALL be a single module with no sub-modules; the idx and vec counters SHALL be inline.

Verification
REQ-038 Single vector: rst, then start at T with layer=3, count=1 -> sel=3 and ctrl=8 at T+1; ctrl=9..13 with valid=1 at T+2..T+6; done=1, busy=0, ctrl=0 at T+7.
REQ-039 Multi-vector: start with layer=1, count=3 -> the ctrl sequence 8,9,10,11,12,13 repeats 3 times with vec=0,1,2, and done follows 18 cycles after start.
REQ-040 Stall: assert stall for 2 cycles while ctrl=10 -> ctrl stays 10 with valid=0 for 2 cycles, then 11; done is delayed by exactly 2 cycles.
REQ-041 Abort: assert abort while ctrl=12, vec=1 -> next cycle ctrl=0, sel=0, busy=0, vec=0, with no done pulse.
REQ-042 Illegal start: start with layer=0 (then with count=0) -> err pulses for one cycle, busy stays 0 and ctrl stays 0.
REQ-043 Back-to-back and reset: a start in the done cycle produces ctrl=8 on the next cycle; rst asserted during SHIFT -> all outputs are 0 on the next cycle and no done pulse occurs.
